// File: rtl/conv_pkg.sv
// Shared constants for the convolution window loader: kernel size, fetch FSM
// encodings and the output-dimension helper.
package conv_pkg;

    localparam int unsigned K     = 3;
    localparam int unsigned TAP_W = 2;  // width of a window row/column index

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_LDONE = 2'd3;

    // Number of valid output positions along one axis (stride 1, no padding).
    function automatic int unsigned out_dim(input int unsigned n);
        return n - K + 1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Output-pixel position tracker: row/col walk in raster order, sticky done
// after the last position, and the combinational store address.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              counter_enable,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              done,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int unsigned OW = out_dim(IMG_W);
    localparam int unsigned OH = out_dim(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            done <= 1'b0;
        end else if (start) begin
            row  <= '0;
            col  <= '0;
            done <= 1'b0;
        end else if (counter_enable && !done) begin
            if (col != LAST_COL) begin
                col <= col + 1'b1;
            end else if (row != LAST_ROW) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                // Final position: hold row/col so out_addr stays on the last pixel.
                done <= 1'b1;
            end
        end
    end

    assign out_addr = row * ADDR_W'(OW) + col;

endmodule

// File: rtl/conv_window_loader.sv
// Fetches a 3x3 window from synchronous-read memory into row registers for the MAC.
// Optional column reuse on single-column advances: define CONV_WINDOW_REUSE_EN.
module conv_window_loader
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                addr_gen,
    input  logic                load,
    input  logic                counter_enable,
    output logic                load_done,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic [3*DATA_W-1:0] win_row0,
    output logic [3*DATA_W-1:0] win_row1,
    output logic [3*DATA_W-1:0] win_row2,
    output logic [ADDR_W-1:0]   out_addr
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(K - 1);

    logic [ADDR_W-1:0] row, col;
    logic [1:0]        state_q, state_d;
    logic [TAP_W-1:0]  r_q, c_q, cap_r_q, cap_c_q;
    logic              cap_q, partial_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] win_q [K][K];
    logic              accept, abort, last_tap, use_reuse, in_fetch;

    conv_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .counter_enable (counter_enable),
        .row            (row),
        .col            (col),
        .done           (done),
        .out_addr       (out_addr)
    );

    assign in_fetch  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign accept    = (state_q == ST_IDLE) && load;
    assign abort     = in_fetch && !load;
    assign last_tap  = (r_q == LAST_TAP) && (c_q == LAST_TAP);
    assign mem_rd_en = (state_q == ST_FETCH) && load;
    assign mem_addr  = mem_rd_en ?
                       base_q + ADDR_W'(r_q) * ADDR_W'(IMG_W) + ADDR_W'(c_q) : '0;
    assign load_done = (state_q == ST_LDONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_FETCH;
            ST_FETCH: begin
                if (!load)         state_d = ST_IDLE;
                else if (last_tap) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = load ? ST_LDONE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            cap_q     <= 1'b0;
            cap_r_q   <= '0;
            cap_c_q   <= '0;
            partial_q <= 1'b0;
            base_q    <= '0;
        end else begin
            state_q <= state_d;
            // Read data returns one cycle later; remember where it belongs.
            cap_q   <= mem_rd_en;
            cap_r_q <= r_q;
            cap_c_q <= c_q;
            if (addr_gen && state_q == ST_IDLE) begin
                base_q <= row * ADDR_W'(IMG_W) + col;
            end
            if (accept) begin
                r_q       <= '0;
                c_q       <= use_reuse ? LAST_TAP : '0;
                partial_q <= use_reuse;
            end else if (mem_rd_en) begin
                if (c_q == LAST_TAP) begin
                    c_q <= partial_q ? LAST_TAP : '0;
                    r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept && use_reuse) begin
            for (int r = 0; r < K; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
        end else if (in_fetch && cap_q) begin
            win_q[cap_r_q][cap_c_q] <= mem_rd_data;
        end
    end

`ifdef CONV_WINDOW_REUSE_EN
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(out_dim(IMG_W) - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(out_dim(IMG_H) - 1);

    logic              reuse_ok_q, row_wrap;
    logic [ADDR_W-1:0] last_row_q, last_col_q;

    assign row_wrap  = counter_enable && !start && !done &&
                       (col == LAST_COL) && (row != LAST_ROW);
    assign use_reuse = reuse_ok_q && (row == last_row_q) && (col == last_col_q + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reuse_ok_q <= 1'b0;
            last_row_q <= '0;
            last_col_q <= '0;
        end else begin
            if (accept) begin
                last_row_q <= row;
                last_col_q <= col;
            end
            if (start || row_wrap || abort) begin
                reuse_ok_q <= 1'b0;
            end else if (state_q == ST_LDONE && !partial_q) begin
                reuse_ok_q <= 1'b1;
            end
        end
    end
`else
    assign use_reuse = 1'b0;
`endif

    assign win_row0 = {win_q[0][2], win_q[0][1], win_q[0][0]};
    assign win_row1 = {win_q[1][2], win_q[1][1], win_q[1][0]};
    assign win_row2 = {win_q[2][2], win_q[2][1], win_q[2][0]};

endmodule

// File: tb/tb_conv_window_loader.sv
// Scoreboard bench for conv_window_loader: stimulus pushes expected reads, windows
// and positions from a pixel-level model; a negedge monitor pops and compares.
module tb_conv_window_loader;

    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int OW     = IMG_W - 2;
    localparam int OH     = IMG_H - 2;
    localparam int NPIX   = IMG_W * IMG_H;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0, addr_gen = 1'b0, load = 1'b0, counter_enable = 1'b0;
    logic                load_done, done, mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr, out_addr;
    logic [DATA_W-1:0]   mem_rd_data = '0;
    logic [3*DATA_W-1:0] win_row0, win_row1, win_row2;

    conv_window_loader #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .addr_gen       (addr_gen),
        .load           (load),
        .counter_enable (counter_enable),
        .load_done      (load_done),
        .done           (done),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .win_row0       (win_row0),
        .win_row1       (win_row1),
        .win_row2       (win_row2),
        .out_addr       (out_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [NPIX];
    always @(posedge clk)
        if (mem_rd_en)
            mem_rd_data <= (mem_addr < ADDR_W'(NPIX)) ? mem[mem_addr] : 8'hEE;

    typedef struct {
        logic [3*DATA_W-1:0] r0, r1, r2;
        int at;
    } win_t;
    typedef struct {
        logic [ADDR_W-1:0] oa;
        logic dn;
        int at;
    } pos_t;

    logic [ADDR_W-1:0] exp_addr_q[$];
    win_t              exp_win_q[$];
    pos_t              exp_pos_q[$];
    bit                quiet_reads = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: output position, window base and reuse eligibility.
    int m_row = 0, m_col = 0, m_base = 0, m_last_row = 0, m_last_col = 0;
    bit m_done = 1'b0, m_reuse_ok = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [ADDR_W-1:0] a;
        win_t w;
        pos_t p;
        if (rst_n) begin
            if (mem_rd_en && !quiet_reads) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_read", mem_addr, '1);
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("mem_addr", mem_addr, a);
                end
            end
            if (load_done) begin
                if (exp_win_q.size() == 0) begin
                    chk("unexpected_load_done", load_done, 1'b0);
                end else begin
                    w = exp_win_q.pop_front();
                    chk("win_row0", win_row0, w.r0);
                    chk("win_row1", win_row1, w.r1);
                    chk("win_row2", win_row2, w.r2);
                    chk("load_done_cycle", cyc, w.at);
                end
            end
            while (exp_pos_q.size() > 0 && exp_pos_q[0].at <= cyc) begin
                p = exp_pos_q.pop_front();
                chk("out_addr", out_addr, p.oa);
                chk("done", done, p.dn);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pos();
        pos_t p;
        p.oa = ADDR_W'(m_row * OW + m_col);
        p.dn = m_done;
        p.at = cyc;
        exp_pos_q.push_back(p);
    endtask

    function automatic void model_ce();
        if (!m_done) begin
            if (m_col < OW - 1) begin
                m_col++;
            end else if (m_row < OH - 1) begin
                m_col = 0;
                m_row++;
                m_reuse_ok = 1'b0;
            end else begin
                m_done = 1'b1;
            end
        end
    endfunction

    function automatic bit model_reuse();
`ifdef CONV_WINDOW_REUSE_EN
        return m_reuse_ok && m_row == m_last_row && m_col == m_last_col + 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_start(input bit with_ce);
        start = 1'b1;
        counter_enable = with_ce;
        m_row = 0;
        m_col = 0;
        m_done = 1'b0;
        m_reuse_ok = 1'b0;
        tick();
        start = 1'b0;
        counter_enable = 1'b0;
        push_pos();
    endtask

    task automatic pulse_ce();
        counter_enable = 1'b1;
        model_ce();
        tick();
        counter_enable = 1'b0;
        push_pos();
    endtask

    task automatic do_addr_gen();
        addr_gen = 1'b1;
        m_base = m_row * IMG_W + m_col;
        tick();
        addr_gen = 1'b0;
    endtask

    task automatic do_load();
        bit reuse, got;
        win_t w;
        logic [3*DATA_W-1:0] rows [3];
        do_addr_gen();
        reuse = model_reuse();
        m_last_row = m_row;
        m_last_col = m_col;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                rows[r][c*DATA_W +: DATA_W] = mem[m_base + r * IMG_W + c];
                if (!reuse || c == 2) exp_addr_q.push_back(ADDR_W'(m_base + r * IMG_W + c));
            end
        end
        w.r0 = rows[0];
        w.r1 = rows[1];
        w.r2 = rows[2];
        w.at = cyc + (reuse ? 5 : 11);
        exp_win_q.push_back(w);
        load = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) got = 1'b1;
        end
        load = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL load_timeout actual=no_load_done expected=load_done (cycle %0d)", cyc);
            exp_win_q.delete();
            exp_addr_q.delete();
        end
        if (!reuse) m_reuse_ok = 1'b1;
        tick();
    endtask

    task automatic do_abort();
        do_addr_gen();
        m_last_row = m_row;
        m_last_col = m_col;
        quiet_reads = 1'b1;
        load = 1'b1;
        repeat (4) tick();
        load = 1'b0;
        m_reuse_ok = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_rd_en", mem_rd_en, 1'b0);
            chk("abort_load_done", load_done, 1'b0);
        end
        quiet_reads = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_load_done"}, load_done, '0);
        chk({tag, "_done"}, done, '0);
        chk({tag, "_mem_rd_en"}, mem_rd_en, '0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_win_row0"}, win_row0, '0);
        chk({tag, "_win_row1"}, win_row1, '0);
        chk({tag, "_win_row2"}, win_row2, '0);
        chk({tag, "_out_addr"}, out_addr, '0);
    endtask

    task automatic do_reset_mid_fetch();
        do_addr_gen();
        quiet_reads = 1'b1;
        load = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        load = 1'b0;
        exp_addr_q.delete();
        exp_win_q.delete();
        exp_pos_q.delete();
        m_row = 0;
        m_col = 0;
        m_done = 1'b0;
        m_base = 0;
        m_reuse_ok = 1'b0;
        tick();
        rst_n = 1'b1;
        quiet_reads = 1'b0;
        tick();
    endtask

    initial begin
        int n, k;
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'(i);
        #1 check_all_zero("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // First window at (0,0) and a second at (1,2).
        do_start(1'b0);
        do_load();
        repeat (5) pulse_ce();
        do_load();

        // Walk to the end, one ignored pulse, then restart.
        do_start(1'b0);
        repeat (10) pulse_ce();
        do_start(1'b0);

        // Abort mid-fetch, then a normal load.
        do_abort();
        do_load();

        // start wins over a simultaneous counter_enable.
        repeat (4) pulse_ce();
        do_start(1'b1);

        // Neighbouring loads (column reuse when enabled), then reset during a fetch.
        do_load();
        pulse_ce();
        do_load();
        do_reset_mid_fetch();

        // Randomised walk over fresh memory contents.
        do_start(1'b0);
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'($urandom);
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 2);
            repeat (n) pulse_ce();
            k = $urandom_range(0, 9);
            if (k == 0) do_start(1'b0);
            else if (k == 1) do_abort();
            else do_load();
        end

        repeat (3) tick();
        chk("pending_reads", exp_addr_q.size(), 0);
        chk("pending_windows", exp_win_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_loader.md
Name: conv_window_loader

Overview:
- Datapath-side responder to the convolution controller FSM.
- Consumes `addr_gen`, `load` and `counter_enable`; produces `load_done` and `done`.
- Fetches a 3x3 input window from synchronous-read feature-map memory into three row registers that feed the MAC row mux.
- Tracks the output pixel position (stride 1, no padding) and provides the store address.

Parameters:
- IMG_W, 8, input image width in pixels (>= K)
- IMG_H, 8, input image height in pixels (>= K)
- DATA_W, 8, pixel width in bits
- ADDR_W, 12, memory address width; must hold IMG_W*IMG_H-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears position counters and `done`
- addr_gen  in  1  latch window base address from current row/col
- load  in  1  level; request window fetch, held until `load_done` is seen
- counter_enable  in  1  one-cycle pulse; advance output position
- load_done  out  1  one-cycle pulse; window registers valid
- done  out  1  sticky; last output position has been advanced past
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  read data, valid one cycle after `mem_rd_en`
- win_row0/1/2  out  3*DATA_W each  window rows; column 0 in the LSBs
- out_addr  out  ADDR_W  output address = row*OW + col

Behaviour:
- Clock/reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- Derived constants: K=3, OW=IMG_W-K+1, OH=IMG_H-K+1.
- Reset values: all outputs 0, row=col=0, base=0, FSM in IDLE, window registers 0.
- Position counter:
  - `start` sets row=col=0 and done=0. `start` wins over a simultaneous `counter_enable`.
  - `counter_enable` with col<OW-1: col++.
  - `counter_enable` with col==OW-1: col=0, row++.
  - `counter_enable` at (OH-1, OW-1): done=1 on the next edge; row/col hold; later `counter_enable` pulses are ignored.
  - `done` is registered, so it is valid in the controller's check cycle.
- `addr_gen`: base <= row*IMG_W + col. Accepted only in IDLE; ignored otherwise.
- Fetch FSM states: IDLE, FETCH, DRAIN, LDONE.
  - IDLE -> FETCH when load=1.
  - FETCH: issues one read per cycle, idx 0..8, r=idx/3, c=idx%3, mem_addr = base + r*IMG_W + c, mem_rd_en=1. Goes to DRAIN after idx 8.
  - Data is captured each cycle into win_row[r_d][c_d], using the one-cycle-delayed idx.
  - DRAIN: captures the last word, no read issued -> LDONE.
  - LDONE: load_done=1 for exactly one cycle -> IDLE.
- Latency: load high at cycle 0; reads in cycles 1..9; load_done in cycle 11.
- Abort: if `load` drops in FETCH or DRAIN, the FSM returns to IDLE next cycle. No `load_done`; window contents undefined.
- Window registers hold their value outside FETCH/DRAIN.
- out_addr is combinational from row/col.
- Address arithmetic is unsigned, ADDR_W wide; no overflow is possible for legal parameters.
- Reset mid-fetch: immediate return to reset values.

Optional Feature:
- Macro: CONV_WINDOW_REUSE_EN.
- Defined:
  - A `reuse_ok` flag is set by every completed full load and cleared by `start`, row wrap, or abort.
  - If reuse_ok=1 when `load` is accepted, and the position advanced by exactly one column since the last load, the window shifts left one column.
  - Only column 2 is fetched (3 reads, idx 2,5,8). load_done arrives in cycle 5 instead of 11.
- Undefined: every load fetches all 9 words; no reuse state exists.

Decomposition:
- Package conv_pkg holds:
  - K=3
  - fetch FSM state encodings (2 bits)
  - derived-width helper constants
- One natural sub-module, conv_pos_counter, containing row/col/done, start handling and out_addr.
- The fetch FSM and window registers stay in the top module.

Test Plan:
- IMG_W=IMG_H=5, reset, start, then (addr_gen, load) at position (0,0) -> reads 0,1,2,5,6,7,10,11,12. Memory returns addr value. win_row0=={2,1,0}, win_row2=={12,11,10}. load_done in cycle 11, one cycle wide.
- Advance to (1,2) via 5 counter_enable pulses -> out_addr=5; base 7; reads 7,8,9,12,13,14,17,18,19.
- 9 counter_enable pulses from start -> done=1 one cycle after the 9th pulse. A 10th pulse leaves row=2, col=2. start clears done and sets out_addr=0.
- load dropped during the 4th read -> no load_done; FSM back in IDLE next cycle; a new full load succeeds normally.
- start and counter_enable asserted in the same cycle -> row=col=0, done=0; asynchronous rst_n pulse mid-FETCH -> all outputs 0 immediately.
- With CONV_WINDOW_REUSE_EN: full load at (0,0), counter_enable, load at (0,1) -> reads only 3,8,13; window is {3,2,1}/{8,7,6}/{13,12,11}; load_done in cycle 5.
